// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: block geometry, pad byte, padder FSM states.
package sha256_pkg;

  localparam int unsigned BLOCK_W   = 512;
  localparam int unsigned LEN_W     = 64;
  localparam int unsigned MAX_BYTES = (BLOCK_W - LEN_W) / 8 - 1;
  // Byte lanes ahead of the length field: message, 0x80 marker and zero fill.
  localparam int unsigned MSG_LANES = (BLOCK_W - LEN_W) / 8;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [BLOCK_W-1:0] sha_block_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    HOLD   = 2'd2,
    ERR    = 2'd3
  } pad_state_t;

endpackage

// File: rtl/sha256_block_padder_if.sv
// Byte-in / block-out stream bundle for the SHA-256 padder.
// master = message source and hash core side, slave = padder side.
interface sha256_block_padder_if;
  import sha256_pkg::*;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       blk_valid;
  logic       blk_ready;
  sha_block_t blk_data;
  logic       err;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, err
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, err
  );

endinterface

// File: rtl/sha256_block_padder.sv
// Single-block SHA-256 padder: bytes in, FIPS 180-4 padded 512-bit block out.
// Optional SHA256_PAD_OVERFLOW_ERR_EN: overflow latches err instead of truncating.
module sha256_block_padder
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sha256_block_padder_if.slave  bus
);

  pad_state_t state_q, state_d;
  logic [5:0] cnt_q;
  sha_block_t blk_q;
  logic       accept;
  logic       ovf;

  assign accept = bus.in_valid && bus.in_ready;
  assign ovf    = accept && !bus.in_last && (cnt_q == 6'(MAX_BYTES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCEPT: begin
`ifdef SHA256_PAD_OVERFLOW_ERR_EN
        if (ovf)                          state_d = ERR;
        else if (accept && bus.in_last)   state_d = PAD;
`else
        if (accept && (bus.in_last || ovf)) state_d = PAD;
`endif
      end
      PAD:     state_d = HOLD;
      HOLD:    if (bus.blk_ready) state_d = ACCEPT;
      ERR:     state_d = ERR;
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCEPT;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ACCEPT: begin
          if (accept) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
              if (cnt_q == 6'(i)) blk_q[BLOCK_W-1-8*i -: 8] <= bus.in_data;
            end
            cnt_q <= cnt_q + 6'd1;
          end
        end
        PAD: begin
          // cnt_q is the message length n: marker at lane n, zeros above it.
          for (int unsigned i = 0; i < MSG_LANES; i++) begin
            if (cnt_q == 6'(i))     blk_q[BLOCK_W-1-8*i -: 8] <= PAD_BYTE;
            else if (6'(i) > cnt_q) blk_q[BLOCK_W-1-8*i -: 8] <= '0;
          end
          blk_q[LEN_W-1:0] <= LEN_W'({cnt_q, 3'b000});
        end
        HOLD: begin
          if (bus.blk_ready) begin
            cnt_q <= '0;
            blk_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rst && (state_q == ACCEPT);
  assign bus.blk_valid = (state_q == HOLD);
  assign bus.blk_data  = blk_q;
`ifdef SHA256_PAD_OVERFLOW_ERR_EN
  assign bus.err = (state_q == ERR);
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_block_padder.sv
// Scoreboard bench for sha256_block_padder: expected blocks queued at stimulus time,
// popped and compared on every block handshake.
module tb_sha256_block_padder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_block_padder_if bus ();

  sha256_block_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  logic [7:0]   msg [0:63];
  logic [511:0] exp_q [$];
  logic [511:0] snap;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] model_block(input int unsigned n);
    logic [511:0] b;
    b = '0;
    for (int unsigned i = 0; i < n; i++) b[511-8*i -: 8] = msg[i];
    b[511-8*n -: 8] = 8'h80;
    b[63:0] = 64'(n * 8);
    return b;
  endfunction

  // Block consumer side of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.blk_valid && bus.blk_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 512'(exp_q.size()), 512'd1);
      else                   chk("sb_block", bus.blk_data, exp_q.pop_front());
    end
  end

  task automatic wait_ready();
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("accept_timeout", 512'(bus.in_ready), 512'd1);
  endtask

  // Called just after a rising edge; returns just after the edge accepting byte n-1.
  task automatic send_msg(input int unsigned n, input bit with_last, input bit expect_blk);
    for (int unsigned i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = with_last && (i == n - 1);
      if (bus.in_last && expect_blk) exp_q.push_back(model_block(n));
      wait_ready();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk); chk({tag, "_pad_low"}, 512'(bus.blk_valid), 512'd0);
    @(negedge clk); chk({tag, "_valid"}, 512'(bus.blk_valid), 512'd1);
    @(negedge clk); chk({tag, "_one_cycle"}, 512'(bus.blk_valid), 512'd0);
    @(posedge clk); #1;
  endtask

  task automatic load_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  task automatic release_rst();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready",  512'(bus.in_ready),  512'd0);
    chk("rst_blk_valid", 512'(bus.blk_valid), 512'd0);
    chk("rst_blk_data",  bus.blk_data,        512'd0);
    chk("rst_err",       512'(bus.err),       512'd0);
    release_rst();
    chk("post_rst_ready", 512'(bus.in_ready), 512'd1);

    // "abc" with consumer always ready
    bus.blk_ready = 1'b1;
    load_abc();
    exp_q.push_back(ABC_BLK);
    send_msg(3, 1'b1, 1'b0);
    check_latency("abc");

    // "Hello, SHA-256!" under 10 cycles of backpressure
    bus.blk_ready = 1'b0;
    begin
      logic [119:0] hello;
      hello = 120'h48656c6c6f2c205348412d32353621;
      for (int i = 0; i < 15; i++) msg[i] = hello[119-8*i -: 8];
    end
    send_msg(15, 1'b1, 1'b1);
    @(negedge clk); chk("hello_pad_low", 512'(bus.blk_valid), 512'd0);
    @(negedge clk); chk("hello_valid", 512'(bus.blk_valid), 512'd1);
    snap = bus.blk_data;
    chk("hello_msg",    512'(snap[511:392]), 512'(120'h48656c6c6f2c205348412d32353621));
    chk("hello_marker", 512'(snap[391:384]), 512'h80);
    chk("hello_len",    512'(snap[63:0]),    512'h78);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid",    512'(bus.blk_valid), 512'd1);
      chk("bp_stable",   bus.blk_data,        snap);
      chk("bp_in_ready", 512'(bus.in_ready),  512'd0);
    end
    @(posedge clk); #1; bus.blk_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", 512'(bus.in_ready), 512'd1);
    chk("bp_release_data",  bus.blk_data,       512'd0);
    @(posedge clk); #1;

    // Maximum-length message, 0x00..0x36
    for (int i = 0; i < 55; i++) msg[i] = 8'(i);
    send_msg(55, 1'b1, 1'b1);
    check_latency("max55");
    chk("max55_err", 512'(bus.err), 512'd0);

    // Message running past 55 bytes
    send_msg(55, 1'b0, 1'b0);
`ifdef SHA256_PAD_OVERFLOW_ERR_EN
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h37;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ovf_err",       512'(bus.err),       512'd1);
      chk("ovf_no_valid",  512'(bus.blk_valid), 512'd0);
      chk("ovf_no_ready",  512'(bus.in_ready),  512'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("ovf_rst_err", 512'(bus.err), 512'd0);
    release_rst();
`else
    exp_q.push_back(model_block(55));
    check_latency("trunc");
    chk("trunc_err", 512'(bus.err), 512'd0);
`endif

    // Reset while in PAD
    bus.blk_ready = 1'b0;
    load_abc();
    send_msg(3, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_pad_valid", 512'(bus.blk_valid), 512'd0);
    chk("rst_pad_data",  bus.blk_data,        512'd0);
    chk("rst_pad_ready", 512'(bus.in_ready),  512'd0);
    repeat (2) @(negedge clk);
    chk("rst_pad_hold_low", 512'(bus.blk_valid), 512'd0);
    release_rst();

    // Reset while in HOLD
    send_msg(3, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_before_rst", 512'(bus.blk_valid), 512'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_hold_valid", 512'(bus.blk_valid), 512'd0);
    chk("rst_hold_data",  bus.blk_data,        512'd0);
    release_rst();

    // Clean "abc" after aborted blocks
    bus.blk_ready = 1'b1;
    exp_q.push_back(ABC_BLK);
    send_msg(3, 1'b1, 1'b0);
    check_latency("abc_again");

    repeat (5) @(negedge clk);
    chk("sb_drained", 512'(exp_q.size()), 512'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
